// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory responder.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // Byte offset bits inside a word.
  localparam int unsigned WORD_OFF = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous byte-enable write, registered read.
// Contents are not reset.
module dmem_array
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      be,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(DATA_W / 8); i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed wait,
// response held until accepted.
// Optional feature macro: DMEM_ERR_EN (flags misaligned / out-of-range accesses).
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LANES = DATA_W / 8;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;
  logic              err_q;

  logic              accept;
  logic              commit;
  logic              req_err;
  logic              cur_we;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [LANES-1:0]  cur_be;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  assign accept = req_valid && req_ready;

`ifdef DMEM_ERR_EN
  assign req_err = (req_addr[WORD_OFF-1:0] != '0) || (req_addr >= ADDR_W'(DEPTH * 4));
`else
  assign req_err = 1'b0;
  // Offset and upper address bits are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{req_addr[WORD_OFF-1:0], req_addr[ADDR_W-1:WORD_OFF+IDX_W]};
`endif

  // With zero wait the RAM is accessed on the accept edge itself, so the
  // live request is used before the latched copy exists.
  assign cur_we    = (state == IDLE) ? req_we                      : we_q;
  assign cur_idx   = (state == IDLE) ? req_addr[WORD_OFF +: IDX_W] : idx_q;
  assign cur_wdata = (state == IDLE) ? req_wdata                   : wdata_q;
  assign cur_be    = (state == IDLE) ? req_be                      : be_q;
  assign cur_err   = (state == IDLE) ? req_err                     : err_q;

  assign commit = ((state == WAIT) && (cnt == 4'd0)) ||
                  ((state == IDLE) && accept && (WAIT_CYCLES == 0));
  assign wr_en  = commit && !reset && cur_we && !cur_err;
  assign rd_en  = commit && !reset && !cur_we && !cur_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (rd_word)
  );

  // State, wait counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[WORD_OFF +: IDX_W];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        err_q   <= req_err;
      end
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; read data only surfaces for clean loads.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? rd_word : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level reference model.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .DEPTH       (64),
    .WAIT_CYCLES (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory image plus one in-flight transaction described by its age in cycles.
  logic [31:0] m_mem [64];
  bit   [63:0] m_known = '0;
  bit          m_busy  = 1'b0;
  int          m_age   = 0;
  logic        m_we    = 1'b0;
  logic [5:0]  m_idx   = '0;
  logic [31:0] m_wd    = '0;
  logic [3:0]  m_be    = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_exp_rd = '0;
  bit          m_exp_known = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'd256);
`else
    return 1'b0;
`endif
  endfunction

  wire exp_valid = m_busy && (m_age >= W);
  wire exp_ready = !m_busy && !reset;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_we   <= req_we;
        m_idx  <= req_addr[7:2];
        m_wd   <= req_wdata;
        m_be   <= req_be;
        m_err  <= bad_addr(req_addr);
      end
    end else if (m_age >= W) begin
      if (rsp_ready) m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == W) begin
        if (m_we && !m_err && (m_be != 4'h0)) begin
          m_mem[m_idx]   <= merge(m_mem[m_idx], m_wd, m_be);
          m_known[m_idx] <= m_known[m_idx] | (m_be == 4'hF);
        end
        m_exp_rd    <= (m_we || m_err) ? 32'h0 : m_mem[m_idx];
        m_exp_known <= (m_we || m_err) ? 1'b1 : m_known[m_idx];
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
      check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
      if (exp_valid) begin
        check("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
        if (m_exp_known) check("rsp_rdata", rsp_rdata, m_exp_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, input bit poke,
                      output logic [31:0] rd, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<20", n);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      failures++;
      $display("FAIL rsp_timeout actual=%0d required=<40", lat);
    end
    rd  = rsp_rdata;
    err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
      end
      @(negedge clk);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      check("bp_rdata_stable", rsp_rdata, rd);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // Full-word store, latency, read back.
    xact(1'b1, 32'h18, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er, lat);
    check("store_latency", lat, W + 1);
    check("store_rdata_zero", rd, 32'h0);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("load_deadbeef", rd, 32'hDEAD_BEEF);
    check("load_latency", lat, 3);

    // Partial and empty byte enables.
    xact(1'b1, 32'h18, 32'h0000_00AA, 4'h1, 0, 1'b0, rd, er, lat);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("load_be1", rd, 32'hDEAD_BEAA);
    xact(1'b1, 32'h18, 32'h5555_5555, 4'h0, 0, 1'b0, rd, er, lat);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("load_be0", rd, 32'hDEAD_BEAA);

    // Response backpressure with an ignored extra request.
    xact(1'b0, 32'h18, 32'h0, 4'h0, 5, 1'b1, rd, er, lat);
    check("bp_rdata", rd, 32'hDEAD_BEAA);
    @(negedge clk);
    check("bp_idle_after", {31'h0, req_ready}, 32'h1);

    // Reset during WAIT drops the store.
    xact(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h1234_5678; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("rst_drop_store", rd, 32'hCAFE_F00D);

    // Aliasing modulo 256 bytes.
    xact(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, 1'b0, rd, er, lat);
    xact(1'b0, 32'h118, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("alias_118", rd, 32'hDEAD_BEAA);

    // Misaligned store and out-of-range load.
    xact(1'b1, 32'h19, 32'h7777_7777, 4'hF, 0, 1'b0, rd, er, lat);
`ifdef DMEM_ERR_EN
    check("err_store_flag", {31'h0, er}, 32'h1);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("err_store_nowrite", rd, 32'hDEAD_BEAA);
    xact(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("err_load_flag", {31'h0, er}, 32'h1);
    check("err_load_rdata", rd, 32'h0);
`else
    check("noerr_store_flag", {31'h0, er}, 32'h0);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("noerr_store_alias", rd, 32'h7777_7777);
    xact(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("noerr_load_flag", {31'h0, er}, 32'h0);
    check("noerr_load_rdata", rd, 32'h0BAD_F00D);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
